// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix pins plus the decoded key event outputs.
//   row_in      keypad rows, active-low, asynchronous to clk
//   col_out     column drive, active-low one-hot
//   key_code    accepted key {col[1:0], row[1:0]}
//   key_valid   one-clk press pulse
//   key_release one-clk release pulse
//   key_down    level, high while an accepted key is held
// master: the scanner side; slave: the keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_down;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_release, key_down
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_release, key_down
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with sweep-level debounce and decode.
//   clk    system clock
//   rst_n  synchronous reset, active-low
//   bus    keypad_scan_if.master (rows in, columns and key events out)
// Each column is driven for SCAN_DIV clocks; its rows are captured on the last
// clock of that window. A full 4-column sweep is classified as NONE, a single
// KEY or MULTI and debounced over DEB_CNT identical sweeps.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEB_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keypad_scan_if.master        bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CNT);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_t;
  typedef enum logic       {IDLE, PRESS} state_t;

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [15:0]      snap;
  logic             sweep_done;
  cand_t            prev_kind;
  logic [3:0]       prev_code;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rel_cnt;
  state_t           state;

  logic             tick_c;
  cand_t            cand_kind_c;
  logic [3:0]       cand_code_c;
  logic [4:0]       bits_c;
  logic             same_c;
  logic [CNT_W-1:0] deb_next_c;
  logic [CNT_W-1:0] rel_next_c;
  logic             stable_c;
  logic             held_match_c;

  assign tick_c = (div == DIV_MAX);

  // Classify the snapshot: count set bits and remember the last set index.
  always_comb begin
    bits_c      = 5'd0;
    cand_code_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        bits_c      = bits_c + 5'd1;
        cand_code_c = 4'(i);
      end
    end
    if (bits_c == 5'd0)      cand_kind_c = CAND_NONE;
    else if (bits_c == 5'd1) cand_kind_c = CAND_KEY;
    else                     cand_kind_c = CAND_MULTI;
  end

  // Debounce and release counter next values, both saturating at DEB_CNT.
  always_comb begin
    same_c       = (cand_kind_c == prev_kind) &&
                   ((cand_kind_c != CAND_KEY) || (cand_code_c == prev_code));
    deb_next_c   = same_c ? ((deb_cnt >= DEB_MAX) ? DEB_MAX : deb_cnt + CNT_W'(1))
                          : CNT_W'(1);
    stable_c     = (deb_next_c == DEB_MAX);
    rel_next_c   = (rel_cnt >= DEB_MAX) ? DEB_MAX : rel_cnt + CNT_W'(1);
    held_match_c = (cand_kind_c == CAND_KEY) && (cand_code_c == bus.key_code);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1          <= 4'hF;
      row_s2          <= 4'hF;
      div             <= '0;
      col_idx         <= 2'd0;
      bus.col_out     <= 4'b1110;
      snap            <= 16'd0;
      sweep_done      <= 1'b0;
      prev_kind       <= CAND_NONE;
      prev_code       <= 4'd0;
      deb_cnt         <= '0;
      rel_cnt         <= '0;
      state           <= IDLE;
      bus.key_code    <= 4'd0;
      bus.key_valid   <= 1'b0;
      bus.key_release <= 1'b0;
      bus.key_down    <= 1'b0;
    end else begin
      row_s1          <= bus.row_in;
      row_s2          <= row_s1;
      bus.key_valid   <= 1'b0;
      bus.key_release <= 1'b0;
      sweep_done      <= 1'b0;

      // Column scan: capture rows (1 = pressed) and move to the next column.
      if (tick_c) begin
        div                         <= '0;
        snap[{col_idx, 2'b00} +: 4] <= ~row_s2;
        col_idx                     <= col_idx + 2'd1;
        bus.col_out                 <= ~(4'b0001 << (col_idx + 2'd1));
        sweep_done                  <= (col_idx == 2'd3);
      end else begin
        div <= div + DIV_W'(1);
      end

      // Evaluate once per completed sweep.
      if (sweep_done) begin
        prev_kind <= cand_kind_c;
        prev_code <= cand_code_c;
        deb_cnt   <= deb_next_c;
        case (state)
          IDLE: begin
            if ((cand_kind_c == CAND_KEY) && stable_c) begin
              state         <= PRESS;
              bus.key_code  <= cand_code_c;
              bus.key_valid <= 1'b1;
              bus.key_down  <= 1'b1;
              rel_cnt       <= '0;
            end
          end
          PRESS: begin
            if (held_match_c) begin
              rel_cnt <= '0;
            end else if (rel_next_c == DEB_MAX) begin
              state           <= IDLE;
              bus.key_release <= 1'b1;
              bus.key_down    <= 1'b0;
              rel_cnt         <= '0;
            end else begin
              rel_cnt <= rel_next_c;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan with a modelled key matrix.
module tb_keypad_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] keys = 16'd0;

  keypad_scan_if kif();

  keypad_scan #(.SCAN_DIV(4), .DEB_CNT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        if (!kif.col_out[c] && keys[c*4+rr]) r[rr] = 1'b0;
    kif.row_in = r;
  end

  typedef struct {
    bit         rel;
    logic [3:0] code;
    int         sw;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int sw = 0;
  int since = 0;
  logic [3:0] prev_col = 4'h0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts sweeps (0111 -> 1110) and checks every key event.
  always @(negedge clk) begin
    exp_t e;
    if (prev_col == 4'b0111 && kif.col_out == 4'b1110) begin
      sw++;
      since = 0;
    end else begin
      since++;
    end
    prev_col = kif.col_out;
    if (kif.key_valid === 1'b1 && kif.key_release === 1'b1)
      chk("valid_and_release", 1, 0);
    if (kif.key_valid === 1'b1 || kif.key_release === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_event", int'(kif.key_release), -1);
      end else begin
        e = q.pop_front();
        chk("evt_kind", int'(kif.key_release), int'(e.rel));
        chk("evt_code", int'(kif.key_code), int'(e.code));
        chk("evt_sweep", sw, e.sw);
        chk("evt_phase", since, 1);
        chk("evt_down", int'(kif.key_down), e.rel ? 0 : 1);
      end
    end
  end

  task automatic wait_sweep();
    int tgt;
    int n;
    tgt = sw + 1;
    n = 0;
    while (sw < tgt && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (sw < tgt) chk("sweep_timeout", sw, tgt);
  endtask

  task automatic sweeps(input int n);
    for (int i = 0; i < n; i++) wait_sweep();
  endtask

  task automatic push(input bit rel, input int s);
    exp_t e;
    e.rel = rel;
    e.code = 4'h9;
    e.sw = s;
    q.push_back(e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [3:0] ec;
    // Reset, then idle scan with no key pressed.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_col", int'(kif.col_out), 14);
    chk("rst_code", int'(kif.key_code), 0);
    chk("rst_down", int'(kif.key_down), 0);
    for (int j = 1; j < 64; j++) begin
      @(negedge clk);
      ec = ~(4'b0001 << ((j / 4) % 4));
      chk("idle_col", int'(kif.col_out), int'(ec));
      chk("idle_quiet", int'({kif.key_valid, kif.key_release, kif.key_down}), 0);
    end
    #1;

    // Press key 9 (row1/col2), hold, release.
    wait_sweep();
    base = sw;
    keys = 16'h0200;
    push(1'b0, base + 2);
    sweeps(12);
    chk("hold_down", int'(kif.key_down), 1);
    keys = 16'd0;
    push(1'b1, base + 14);
    sweeps(4);
    chk("rel_down", int'(kif.key_down), 0);
    chk("rel_code", int'(kif.key_code), 9);

    // Bounce: toggle every sweep for 6 sweeps, then hold.
    base = sw;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      sweeps(1);
    end
    keys = 16'h0200;
    push(1'b0, base + 8);
    sweeps(3);
    keys = 16'd0;
    push(1'b1, sw + 2);
    sweeps(4);

    // Two keys at once never produce a press.
    keys = 16'h0021;
    sweeps(5);
    chk("multi_down", int'(kif.key_down), 0);
    keys = 16'd0;
    sweeps(3);

    // Reset while held: clears state, no release, fresh press after 2 sweeps.
    keys = 16'h0200;
    push(1'b0, sw + 2);
    sweeps(4);
    chk("pre_rst_down", int'(kif.key_down), 1);
    n = 0;
    while (kif.col_out != 4'b1101 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("find_col1", int'(kif.col_out), 13);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_down", int'(kif.key_down), 0);
    chk("mid_rst_code", int'(kif.key_code), 0);
    chk("mid_rst_col", int'(kif.col_out), 14);
    chk("mid_rst_rel", int'(kif.key_release), 0);
    push(1'b0, sw + 2);
    sweeps(4);
    keys = 16'd0;
    push(1'b1, sw + 2);
    sweeps(4);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
